led_page_scheduler: RTL
=======================

# led_page_scheduler

Sequencing controller for the board's debug LED page mux. It owns the 8-bit page select that drives the mux and offers three display modes. Manual mode follows the switches. Auto-scan steps through a page range on a dwell timer. Trigger-freeze stalls the CPU, sweeps a page range into a snapshot buffer in consecutive cycles, then lets the user browse the frozen snapshot with a step button. It sits between the board switches/buttons, the page mux, the LEDs and the CPU hold logic.

## Interface
Parameters:
- DWELL_CYCLES, 25000000: clk cycles per page in auto-scan; must be ≥1.
- HOLD_SETTLE, 2: cycles between asserting cpu_hold and the first capture sample.
- CAP_DEPTH, 64: snapshot buffer entries; power of two, ≤256.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sw  in  16  board switches; sw[15:8] is the manual page.
- mode  in  2  00 manual, 01 auto-scan, 10 trigger-freeze, 11 treated as 00.
- scan_lo  in  8  first page of the scan/capture range.
- scan_hi  in  8  last page of the scan/capture range.
- step  in  1  debounced button level; the block edge-detects it internally.
- trig  in  1  capture trigger level, e.g. a PC-match; the block edge-detects it internally.
- led_data_in  in  16  page mux output for the current page_sel, combinational.
- page_sel  out  8  page select to the mux, registered.
- led_out  out  16  value driven to the LEDs, registered.
- cpu_hold  out  1  stalls the CPU pipeline while high.
- frozen  out  1  high while a snapshot is being reviewed.
- scan_wrap  out  1  one-cycle pulse when auto-scan wraps from scan_hi to scan_lo.

## Operation
- Range count: n = scan_hi − scan_lo + 1, clamped to CAP_DEPTH. If scan_lo > scan_hi, n = 1 and the range is {scan_lo}.
- Rising edge of step or trig: input high this cycle, low the previous cycle. The previous-cycle register resets to 0.
- States are MANUAL, SCAN, ARMED, CAPTURE and REVIEW. Reset enters MANUAL.
- In MANUAL, SCAN and ARMED, mode is sampled every cycle: 00/11 go to MANUAL, 01 to SCAN, 10 to ARMED.
- MANUAL: page_sel <= sw[15:8]; led_out <= led_data_in.
- SCAN:
  - On entry, page_sel <= scan_lo and the dwell counter clears. led_out <= led_data_in.
  - The counter runs 0..DWELL_CYCLES−1. At its terminal count, page_sel advances by one.
  - If page_sel == scan_hi, or the range is a single page, the advance goes to scan_lo instead and scan_wrap pulses.
  - A step edge advances immediately, using the same wrap rule, and clears the counter.
- ARMED:
  - Display behaves as in MANUAL.
  - A trig edge enters CAPTURE: cpu_hold <= 1, page_sel <= scan_lo, and the capture index and settle counter clear.
- CAPTURE:
  - Wait HOLD_SETTLE cycles with page_sel = scan_lo.
  - Then, once per cycle: buf[idx] <= led_data_in, idx++, page_sel++.
  - After the n-th sample, go to REVIEW: cpu_hold <= 0, frozen <= 1, review index r <= 0.
  - mode, step and trig are ignored throughout CAPTURE.
  - scan_lo and scan_hi are latched on entry to CAPTURE and used by CAPTURE and REVIEW.
- REVIEW:
  - led_out <= buf[r]; page_sel <= latched scan_lo + r, 8-bit wrap.
  - A step edge sets r <= (r == n−1) ? 0 : r+1.
  - trig is ignored.
  - mode ≠ 10 leaves REVIEW for the corresponding state and clears frozen.
  - To re-arm, mode must leave 10 and return to it.
- page_sel arithmetic is 8-bit modulo. Page 0xFF advancing goes to 0x00 only if the range includes 0x00.

## Timing
- Reset values: page_sel 0x00, led_out 0x0000, cpu_hold 0, frozen 0, scan_wrap 0. All counters, indices and edge registers are 0.
- MANUAL latency from sw to led_out: 2 cycles. page_sel follows sw after 1 cycle; led_out registers the mux output 1 cycle later.
- Capture, trig edge at cycle T:
  - cpu_hold and page_sel = scan_lo from T+1.
  - Samples at T+1+HOLD_SETTLE … T+HOLD_SETTLE+n.
  - cpu_hold low and frozen high from T+HOLD_SETTLE+n+1.
  - Total hold duration: HOLD_SETTLE+n cycles.
- Step edge in SCAN or REVIEW: page_sel changes on the next cycle. In REVIEW, led_out also changes on the next cycle.
- Simultaneous dwell terminal count and step edge: advance exactly once.
- Simultaneous trig edge and mode change in ARMED: the mode change wins and no capture starts.
- Reset asserted mid-CAPTURE: cpu_hold drops asynchronously and the buffer contents become don't-care.

## Test plan
- MANUAL: set sw = 0x1A00 → page_sel = 0x1A after 1 cycle; with led_data_in = 0xBEEF, led_out = 0xBEEF 2 cycles after sw.
- SCAN, DWELL_CYCLES=4, scan_lo=0x30, scan_hi=0x32 → page_sel 30,31,32,30, each held 4 cycles; scan_wrap pulses exactly once per wrap; a step edge mid-dwell advances on the next cycle and restarts the dwell.
- SCAN with scan_lo=0x40, scan_hi=0x3F → page_sel stays 0x40 and scan_wrap pulses every 4 cycles.
- Freeze, HOLD_SETTLE=2, range 0x30..0x33, bench drives led_data_in = {8'hA5, page_sel} → cpu_hold high for 6 cycles; buffer holds A530..A533; frozen=1; led_out=A530; three step edges give A531, A532, A533; a fourth gives A530.
- Range 0x00..0xFF with CAP_DEPTH=64 → exactly 64 samples and 66 hold cycles; REVIEW wraps at r=63.
- Drop rst low at the 3rd capture sample → cpu_hold=0 immediately; after release, state is MANUAL and all outputs hold their reset values.

Source files
------------

// File: rtl/led_page_scheduler.sv
// Debug LED page sequencer: drives the page mux select and the LEDs in
// manual, auto-scan and trigger-freeze (capture + review) modes.
module led_page_scheduler #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned HOLD_SETTLE  = 2,
  parameter int unsigned CAP_DEPTH    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [1:0]  mode,
  input  logic [7:0]  scan_lo,
  input  logic [7:0]  scan_hi,
  input  logic        step,
  input  logic        trig,
  input  logic [15:0] led_data_in,
  output logic [7:0]  page_sel,
  output logic [15:0] led_out,
  output logic        cpu_hold,
  output logic        frozen,
  output logic        scan_wrap
);

  localparam int unsigned IDX_W = (CAP_DEPTH > 1) ? $clog2(CAP_DEPTH) : 1;
  localparam int unsigned DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned ST_W  = (HOLD_SETTLE > 0) ? $clog2(HOLD_SETTLE + 1) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST  = DW_W'(DWELL_CYCLES - 1);
  localparam logic [ST_W-1:0] SETTLE_DONE = ST_W'(HOLD_SETTLE);
  localparam logic [8:0]      CAP_N       = 9'(CAP_DEPTH);

  typedef enum logic [2:0] {
    ST_MANUAL  = 3'd0,
    ST_SCAN    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_REVIEW  = 3'd4
  } state_e;

  // Number of pages in a range; an inverted range collapses to {lo}.
  function automatic logic [8:0] range_count(input logic [7:0] lo, input logic [7:0] hi);
    logic [8:0] span;
    span = {1'b0, hi} - {1'b0, lo} + 9'd1;
    if (lo > hi) begin
      range_count = 9'd1;
    end else if (span > CAP_N) begin
      range_count = CAP_N;
    end else begin
      range_count = span;
    end
  endfunction

  // State requested by the mode switches (11 behaves like 00).
  function automatic state_e mode_target(input logic [1:0] m);
    case (m)
      2'b01:   mode_target = ST_SCAN;
      2'b10:   mode_target = ST_ARMED;
      default: mode_target = ST_MANUAL;
    endcase
  endfunction

  state_e            state_q, state_d, target_s;
  logic [7:0]        page_q, page_d;
  logic [15:0]       led_q, led_d;
  logic              hold_q, hold_d;
  logic              frozen_q, frozen_d;
  logic              wrap_q, wrap_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rev_q, rev_d, rev_nx_s;
  logic [7:0]        lo_lat_q, lo_lat_d;
  logic [7:0]        hi_lat_q, hi_lat_d;
  logic              step_prev_q, trig_prev_q;
  logic              step_rise_s, trig_rise_s;
  logic              scan_wrap_cond_s;
  logic [8:0]        n_lat_s;
  logic              cap_we_s;
  logic [15:0]       buf_mem [CAP_DEPTH];
  logic              unused_s;

  assign unused_s         = ^sw[7:0];
  assign step_rise_s      = step & ~step_prev_q;
  assign trig_rise_s      = trig & ~trig_prev_q;
  assign scan_wrap_cond_s = (page_q == scan_hi) || (scan_lo >= scan_hi);
  assign n_lat_s          = range_count(lo_lat_q, hi_lat_q);

  // Next-state and datapath decisions for all modes.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    led_d    = led_q;
    hold_d   = hold_q;
    frozen_d = frozen_q;
    wrap_d   = 1'b0;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    rev_d    = rev_q;
    rev_nx_s = rev_q;
    lo_lat_d = lo_lat_q;
    hi_lat_d = hi_lat_q;
    cap_we_s = 1'b0;
    target_s = mode_target(mode);
    case (state_q)
      ST_MANUAL, ST_SCAN, ST_ARMED: begin
        state_d = target_s;
        if (target_s == ST_SCAN) begin
          led_d = led_data_in;
          if (state_q != ST_SCAN) begin
            page_d  = scan_lo;
            dwell_d = '0;
          end else if (step_rise_s || (dwell_q == DWELL_LAST)) begin
            // Step and dwell expiry in the same cycle advance only once.
            dwell_d = '0;
            if (scan_wrap_cond_s) begin
              page_d = scan_lo;
              wrap_d = 1'b1;
            end else begin
              page_d = page_q + 8'd1;
            end
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end else if ((state_q == ST_ARMED) && (target_s == ST_ARMED) && trig_rise_s) begin
          state_d  = ST_CAPTURE;
          hold_d   = 1'b1;
          page_d   = scan_lo;
          settle_d = '0;
          idx_d    = '0;
          lo_lat_d = scan_lo;
          hi_lat_d = scan_hi;
        end else begin
          page_d = sw[15:8];
          led_d  = led_data_in;
        end
      end
      ST_CAPTURE: begin
        if (settle_q != SETTLE_DONE) begin
          settle_d = settle_q + ST_W'(1);
        end else begin
          cap_we_s = 1'b1;
          page_d   = page_q + 8'd1;
          if (9'(idx_q) == (n_lat_s - 9'd1)) begin
            state_d  = ST_REVIEW;
            hold_d   = 1'b0;
            frozen_d = 1'b1;
            rev_d    = '0;
            page_d   = lo_lat_q;
            // Entry 0 is still being written when the range is one page.
            if (idx_q == '0) begin
              led_d = led_data_in;
            end else begin
              led_d = buf_mem[0];
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_REVIEW: begin
        if (target_s != ST_ARMED) begin
          state_d  = target_s;
          frozen_d = 1'b0;
          led_d    = led_data_in;
          if (target_s == ST_SCAN) begin
            page_d  = scan_lo;
            dwell_d = '0;
          end else begin
            page_d = sw[15:8];
          end
        end else begin
          if (step_rise_s) begin
            if (9'(rev_q) == (n_lat_s - 9'd1)) begin
              rev_nx_s = '0;
            end else begin
              rev_nx_s = rev_q + IDX_W'(1);
            end
          end else begin
            rev_nx_s = rev_q;
          end
          rev_d  = rev_nx_s;
          led_d  = buf_mem[rev_nx_s];
          page_d = lo_lat_q + 8'(rev_nx_s);
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // State, output and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_MANUAL;
      page_q      <= 8'h00;
      led_q       <= 16'h0000;
      hold_q      <= 1'b0;
      frozen_q    <= 1'b0;
      wrap_q      <= 1'b0;
      dwell_q     <= '0;
      settle_q    <= '0;
      idx_q       <= '0;
      rev_q       <= '0;
      lo_lat_q    <= 8'h00;
      hi_lat_q    <= 8'h00;
      step_prev_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      led_q       <= led_d;
      hold_q      <= hold_d;
      frozen_q    <= frozen_d;
      wrap_q      <= wrap_d;
      dwell_q     <= dwell_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      rev_q       <= rev_d;
      lo_lat_q    <= lo_lat_d;
      hi_lat_q    <= hi_lat_d;
      step_prev_q <= step;
      trig_prev_q <= trig;
    end
  end

  // Snapshot buffer; contents are meaningless until a capture completes.
  always_ff @(posedge clk) begin
    if (cap_we_s) begin
      buf_mem[idx_q] <= led_data_in;
    end
  end

  assign page_sel  = page_q;
  assign led_out   = led_q;
  assign cpu_hold  = hold_q;
  assign frozen    = frozen_q;
  assign scan_wrap = wrap_q;

endmodule
